tmds_encoder: RTL and testbench
===============================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have parameter PIPE_QM, default 1, meaning: 1 inserts a register after the 8b->9b stage (total latency 2 cycles), 0 omits it (latency 1 cycle).
REQ-002 The block SHALL have port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port data_in, input, 8 bits: pixel byte, sampled every cycle.
REQ-005 The block SHALL have port control_in, input, 2 bits: {C1,C0} control bits, used when ve_in=0.
REQ-006 The block SHALL have port ve_in, input, 1 bit: video enable; 1 selects data symbol, 0 selects control symbol.
REQ-007 The block SHALL have port tmds_out, output, 10 bits: registered TMDS symbol, bit 0 transmitted first.

Function
REQ-008 The block SHALL accept one input set per cycle with no stall and no backpressure; throughput is one symbol per cycle.
REQ-009 The block SHALL produce, for the set sampled at cycle N, tmds_out at cycle N+2 (PIPE_QM=1) or N+1 (PIPE_QM=0); ve_in and control_in SHALL be delayed in lockstep with q_m.
REQ-010 The stage-1 q_m[8:0] SHALL be formed by the existing minimised-transition rule: ones(data_in)>4, or ones=4 with data_in[0]=0 -> XNOR chain with q_m[8]=0; otherwise XOR chain with q_m[8]=1; q_m[0]=data_in[0].
REQ-011 The block SHALL hold a 5-bit signed running-disparity tally; N1 = ones(q_m[7:0]) and N0 = 8-N1.
REQ-012 If tally==0 or N1==N0, the block SHALL output {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}, with tally += (q_m[8] ? N1-N0 : N0-N1).
REQ-013 Else if (tally>0 and N1>N0) or (tally<0 and N0>N1), the block SHALL output {1, q_m[8], ~q_m[7:0]}, with tally += 2*q_m[8] + (N0-N1).
REQ-014 Otherwise the block SHALL output {0, q_m[8], q_m[7:0]}, with tally += (N1-N0) - 2*(~q_m[8]).
REQ-015 With delayed ve=0, the block SHALL output 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011, and SHALL clear the tally to 0 in that same cycle.
REQ-016 The tally SHALL always equal the running (ones-zeros) of the data symbols emitted since the last control symbol or reset, and SHALL stay within [-10,+10]; no saturation logic is required.
REQ-017 On a ve transition 1->0->1 of even one cycle, the first data symbol after the transition SHALL be encoded with tally=0.

Reset
REQ-018 While rst_in=1 at a clock edge, the block SHALL set tmds_out=10'b0 and tally=0, and clear pipeline ve/control registers to ve=0, control=00; this applies equally when reset is asserted mid-stream.
REQ-019 After rst_in deasserts, the block SHALL output 1101010100 (the ctrl-00 symbol) until the first post-reset input reaches the output.

Structure
REQ-020 Package tmds_pkg SHALL hold the four control-symbol constants and the tally width (5).
REQ-021 The 8b->9b stage SHALL be the existing tm_choice sub-module, instantiated once; the popcount of q_m and the disparity/decision logic live in tmds_encoder.

Verification
REQ-022 The bench SHALL cover reset, then ve=0 with control 00 then 11 -> tmds_out = 1101010100 then 1010101011, at latency 2 (PIPE_QM=1) and latency 1 (PIPE_QM=0).
REQ-023 The bench SHALL cover ve=1 with data 0x00 x3 from tally 0 -> 0100000000 (tally -8), 1111111111 (tally +2), 0100000000 (tally -6).
REQ-024 The bench SHALL cover ve=1 with data 0xFF from tally 0 -> 1000000000, tally -8.
REQ-025 The bench SHALL cover 0x00, then ve=0 ctrl=00 for 1 cycle, then 0x00 -> 0100000000, 1101010100, 0100000000 (tally cleared).
REQ-026 The bench SHALL cover rst_in pulsed for 1 cycle with tally=-6 -> tmds_out=0 on the next cycle, then 1101010100, then 0x00 encodes as 0100000000.
REQ-027 The bench SHALL drive 10k random symbols with random ve against a reference model -> bit-exact match, tally == cumulative output disparity, |tally| <= 10.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control-period symbols, disparity tally width and a
// byte popcount used by both the 8b->9b stage and the DC-balance stage.
package tmds_pkg;

  localparam int TALLY_W = 5;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] sym;
    case (c)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/tmds_encoder_tm_choice.sv
// 8b->9b transition-minimising stage: picks an XOR or XNOR chain so the
// resulting q_m has as few internal transitions as possible.
module tm_choice
  import tmds_pkg::*;
(
  input  logic [7:0] data_in,
  output logic [8:0] q_m
);

  logic [3:0] ones;
  logic       use_xnor;

  assign ones     = popcount8(data_in);
  assign use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data_in[0]);

  // Unrolled chain: bit i is the parity of data_in[i:0]; the XNOR chain
  // additionally inverts every odd bit, which avoids a serial bit-to-bit path.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chain
      assign q_m[gi] = (^data_in[gi:0]) ^ (use_xnor & ((gi % 2) == 1));
    end
  endgenerate

  assign q_m[8] = ~use_xnor;

endmodule

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder: transition-minimising stage, optional pipeline register,
// then DC-balancing stage with a running disparity tally and registered output.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int PIPE_QM = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);

  logic [8:0] qm_comb;
  logic [8:0] qm_s;
  logic       ve_s;
  logic [1:0] ctrl_s;

  tm_choice u_tm_choice (
    .data_in (data_in),
    .q_m     (qm_comb)
  );

  generate
    if (PIPE_QM != 0) begin : g_pipe
      logic [8:0] qm_reg;
      logic       ve_reg;
      logic [1:0] ctrl_reg;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          qm_reg   <= '0;
          ve_reg   <= 1'b0;
          ctrl_reg <= 2'b00;
        end else begin
          qm_reg   <= qm_comb;
          ve_reg   <= ve_in;
          ctrl_reg <= control_in;
        end
      end

      assign qm_s   = qm_reg;
      assign ve_s   = ve_reg;
      assign ctrl_s = ctrl_reg;
    end else begin : g_bypass
      assign qm_s   = qm_comb;
      assign ve_s   = ve_in;
      assign ctrl_s = control_in;
    end
  endgenerate

  logic signed [TALLY_W-1:0] tally_reg;
  logic signed [TALLY_W-1:0] tally_next;
  logic signed [TALLY_W-1:0] diff;
  logic        [TALLY_W-1:0] two_n1;
  logic        [9:0]         sym_next;

  // diff = N1 - N0 = 2*N1 - 8; modular 5-bit arithmetic is exact because the
  // tally never leaves [-10, +10].
  assign two_n1 = {popcount8(qm_s[7:0]), 1'b0};
  assign diff   = signed'(two_n1 - 5'd8);

  always_comb begin
    sym_next   = ctrl_symbol(ctrl_s);
    tally_next = '0;
    if (ve_s) begin
      if ((tally_reg == 5'sd0) || (diff == 5'sd0)) begin
        sym_next   = {~qm_s[8], qm_s[8], qm_s[8] ? qm_s[7:0] : ~qm_s[7:0]};
        tally_next = qm_s[8] ? (tally_reg + diff) : (tally_reg - diff);
      end else if (((tally_reg > 5'sd0) && (diff > 5'sd0)) ||
                   ((tally_reg < 5'sd0) && (diff < 5'sd0))) begin
        sym_next   = {1'b1, qm_s[8], ~qm_s[7:0]};
        tally_next = tally_reg + (qm_s[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        sym_next   = {1'b0, qm_s[8], qm_s[7:0]};
        tally_next = tally_reg + diff - (qm_s[8] ? 5'sd0 : 5'sd2);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tmds_out  <= '0;
      tally_reg <= '0;
    end else begin
      tmds_out  <= sym_next;
      tally_reg <= tally_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: two instances (PIPE_QM=0 and 1) share the
// stimulus; a rule-level model queues expected symbols, a monitor checks them.
module tb_tmds_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       ve;
  logic [9:0] tmds_l1;
  logic [9:0] tmds_l2;

  tmds_encoder #(.PIPE_QM(0)) dut_l1 (
    .clk_in     (clk),
    .rst_in     (rst),
    .data_in    (data),
    .control_in (ctrl),
    .ve_in      (ve),
    .tmds_out   (tmds_l1)
  );

  tmds_encoder #(.PIPE_QM(1)) dut_l2 (
    .clk_in     (clk),
    .rst_in     (rst),
    .data_in    (data),
    .control_in (ctrl),
    .ve_in      (ve),
    .tmds_out   (tmds_l2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ve;
    logic [1:0]  ctrl;
    logic [7:0]  data;
    logic        has_gold;
    logic [9:0]  gold;
    logic [95:0] tag;
  } rec_t;

  typedef struct packed {
    logic [9:0]        val;
    logic              is_data;
    logic signed [7:0] tally;
    logic [95:0]       tag;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  rec_t stg = '0;
  int   mt[2];
  int   disp[2];
  int   vec = 0;
  int   errs = 0;

  function automatic logic [9:0] ctrl_of(input logic [1:0] c);
    logic [9:0] tbl [4];
    tbl[0] = 10'b1101010100;
    tbl[1] = 10'b0010101011;
    tbl[2] = 10'b0101010100;
    tbl[3] = 10'b1010101011;
    return tbl[c];
  endfunction

  function automatic logic [8:0] qm_of(input logic [7:0] d);
    logic [8:0] q;
    int  n;
    bit  xn;
    n = $countones(d);
    xn = (n > 4) || (n == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = !xn;
    return q;
  endfunction

  function automatic logic [9:0] encode(input logic [7:0] d, inout int t);
    logic [8:0] qm;
    logic [9:0] o;
    int n1;
    int n0;
    qm = qm_of(d);
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (t == 0 || n1 == n0) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      t += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((t > 0 && n1 > n0) || (t < 0 && n0 > n1)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      t += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      t += (n1 - n0) - (qm[8] ? 0 : 2);
    end
    return o;
  endfunction

  // Drives one input set, then after the edge predicts each instance's output.
  task automatic apply(input logic r, input logic v, input logic [1:0] c,
                       input logic [7:0] d, input logic hg = 1'b0,
                       input logic [9:0] g = '0, input logic [95:0] tag = "rand");
    rec_t cur;
    rec_t eff;
    exp_t e;
    int   t;
    cur = '{ve: v, ctrl: c, data: d, has_gold: hg, gold: g, tag: tag};
    rst  = r;
    ve   = v;
    ctrl = c;
    data = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        eff = cur;
      end else begin
        eff = stg;
        stg = r ? rec_t'('0) : cur;
      end
      e = '0;
      e.tag = eff.tag;
      if (r) begin
        e.val = '0;
        e.tag = "reset";
        mt[k] = 0;
      end else if (!eff.ve) begin
        e.val = ctrl_of(eff.ctrl);
        mt[k] = 0;
      end else begin
        t = mt[k];
        e.val = encode(eff.data, t);
        mt[k] = t;
        e.is_data = 1'b1;
      end
      if (!r && eff.has_gold) e.val = eff.gold;
      e.tally = 8'(mt[k]);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    #1;
  endtask

  task automatic compare(input int k, input logic [9:0] act, input exp_t e);
    vec++;
    if (act !== e.val) begin
      errs++;
      $display("FAIL %0s pipe_qm=%0d symbol: got %b expected %b", e.tag, k, act, e.val);
    end else if (e.tag != "rand") begin
      $display("chk %0s pipe_qm=%0d symbol %b", e.tag, k, act);
    end
    if (e.is_data) begin
      disp[k] += 2 * $countones(act) - 10;
      vec++;
      if (disp[k] != int'(e.tally) || disp[k] > 10 || disp[k] < -10) begin
        errs++;
        $display("FAIL %0s pipe_qm=%0d disparity: got %0d expected %0d (|x|<=10)",
                 e.tag, k, disp[k], e.tally);
      end
    end else begin
      disp[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (sb0.size() > 0) compare(0, tmds_l1, sb0.pop_front());
    if (sb1.size() > 0) compare(1, tmds_l2, sb1.pop_front());
  end

  localparam logic [9:0] S_Z0 = 10'b0100000000;
  localparam logic [9:0] S_Z1 = 10'b1111111111;
  localparam logic [9:0] S_C0 = 10'b1101010100;

  initial begin
    mt[0] = 0;
    mt[1] = 0;
    disp[0] = 0;
    disp[1] = 0;
    rst = 1'b1; ve = 1'b0; ctrl = 2'b00; data = 8'h00;

    apply(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, '0, "reset");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, S_C0, "ctl00");
    apply(1'b0, 1'b0, 2'b11, 8'h00, 1'b1, 10'b1010101011, "ctl11");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, '0, "idle");

    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "zero1");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z1, "zero2");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "zero3");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, '0, "idle");

    apply(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 10'b1000000000, "ones");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, '0, "idle");

    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "veblip_a");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, S_C0, "veblip_c");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "veblip_b");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, '0, "idle");

    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "pre_rst1");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z1, "pre_rst2");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "pre_rst3");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, '0, "fill");
    apply(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, '0, "reset");
    apply(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, S_Z0, "post_rst");
    apply(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, '0, "idle");

    for (int n = 0; n < 10000; n++) begin
      apply(($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    #1;
    vec++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", sb0.size(), sb1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
